// File: rtl/tdm_frame_scheduler_if.sv
// TDM sync inputs, CPU handshake and per-slot strobe outputs of tdm_frame_scheduler.
// The scheduler uses the slave modport; whatever drives the TDM pins and the CPU ack uses master.
interface tdm_frame_scheduler_if #(
  parameter int BIT_W = 5,
  parameter int FRM_W = 1
);
  logic             c4;
  logic             f0;
  logic             enable;
  logic             buf_ack;
  logic             bit_strobe;
  logic [BIT_W-1:0] bit_index;
  logic [FRM_W-1:0] frame_index;
  logic             bank;
  logic             ready_bank;
  logic             cpu_int;
  logic             overrun;
  logic             frame_err;
  logic             locked;

  modport master (
    output c4, f0, enable, buf_ack,
    input  bit_strobe, bit_index, frame_index, bank, ready_bank,
           cpu_int, overrun, frame_err, locked
  );

  modport slave (
    input  c4, f0, enable, buf_ack,
    output bit_strobe, bit_index, frame_index, bank, ready_bank,
           cpu_int, overrun, frame_err, locked
  );
endinterface

// File: rtl/tdm_frame_scheduler.sv
// Frame lock and bit-slot strobe generator for the TDM-to-STM datapath.
// Oversamples c4/f0 on clk50, tracks the c4 phase, and sequences ping-pong banks with a CPU interrupt.
module tdm_frame_scheduler #(
  parameter int BITS_PER_FRAME    = 32,
  parameter int FRAMES_PER_BUFFER = 2,
  parameter int BIT_W             = 5,
  parameter int FRM_W             = 1
) (
  input logic                  clk50,
  input logic                  reset,
  tdm_frame_scheduler_if.slave bus
);
  localparam int              PH_W     = $clog2(2*BITS_PER_FRAME);
  localparam logic [PH_W-1:0] PH_MAX   = PH_W'(2*BITS_PER_FRAME-1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BITS_PER_FRAME-1);
  localparam logic [FRM_W-1:0] LAST_FRM = FRM_W'(FRAMES_PER_BUFFER-1);

  typedef enum logic [1:0] {HUNT, ALIGN, LOCKED} state_e;

  state_e           state_q, state_d;
  logic [2:0]       c4_sync_q, f0_sync_q;
  logic             c4_rise_q, f0_prev_q;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [FRM_W-1:0] frm_q;
  logic             strobe_d, err_d, fs, last, complete;
  logic [BIT_W-1:0] slot;
  logic             strobe_q, err_q, locked_q, bank_q, ready_q, cpu_int_q, overrun_q;
  logic [BIT_W-1:0] bit_index_q;
  logic [FRM_W-1:0] frame_index_q;

  // Stage 3 of each shift chain is the edge-detector history; f0_sync_q[2] lines up with c4_rise_q.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      c4_sync_q <= '0;
      f0_sync_q <= '0;
      c4_rise_q <= 1'b0;
      f0_prev_q <= 1'b0;
    end else begin
      c4_sync_q <= {c4_sync_q[1:0], bus.c4};
      f0_sync_q <= {f0_sync_q[1:0], bus.f0};
      c4_rise_q <= c4_sync_q[1] & ~c4_sync_q[2];
      if (c4_rise_q) f0_prev_q <= f0_sync_q[2];
    end
  end

  assign fs = c4_rise_q & ~f0_sync_q[2] & f0_prev_q;

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) state_q <= HUNT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!bus.enable) begin
      state_d = HUNT;
    end else if (c4_rise_q) begin
      case (state_q)
        HUNT:    if (fs) state_d = ALIGN;
        ALIGN:   if (fs && ph_q == PH_MAX) state_d = LOCKED;
        LOCKED: begin
          if (fs && ph_q != PH_MAX)       state_d = ALIGN;
          else if (!fs && ph_q == PH_MAX) state_d = HUNT;
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // In LOCKED a sync is required exactly at the wrap; either side of that is a violation.
  always_comb begin
    ph_d     = ph_q;
    strobe_d = 1'b0;
    err_d    = 1'b0;
    if (!bus.enable) begin
      ph_d = '0;
    end else if (c4_rise_q) begin
      ph_d = (fs || ph_q == PH_MAX) ? '0 : ph_q + PH_W'(1);
      case (state_q)
        ALIGN:   err_d = fs && (ph_q != PH_MAX);
        LOCKED:  err_d = fs != (ph_q == PH_MAX);
        default: err_d = 1'b0;
      endcase
      strobe_d = (state_d == LOCKED) && !ph_d[0];
    end
  end

  assign slot     = BIT_W'(ph_d >> 1);
  assign last     = strobe_d && (slot == LAST_BIT);
  assign complete = last && (frm_q == LAST_FRM);

  // frame_index reports the frame of the current strobe, so it lags frm_q across a bank flip.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      ph_q          <= '0;
      frm_q         <= '0;
      strobe_q      <= 1'b0;
      err_q         <= 1'b0;
      locked_q      <= 1'b0;
      bit_index_q   <= '0;
      frame_index_q <= '0;
      bank_q        <= 1'b0;
      ready_q       <= 1'b0;
      cpu_int_q     <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      ph_q     <= ph_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
      locked_q <= (state_d == LOCKED);
      if (strobe_d) begin
        bit_index_q   <= slot;
        frame_index_q <= frm_q;
      end
      if (!bus.enable || err_d) begin
        frm_q         <= '0;
        frame_index_q <= '0;
      end else if (last) begin
        frm_q <= complete ? '0 : frm_q + FRM_W'(1);
      end
      if (!bus.enable)   bank_q <= 1'b0;
      else if (complete) bank_q <= ~bank_q;
      // A completion beats a coincident ack; the ack then leaves overrun alone.
      if (complete) begin
        ready_q   <= bank_q;
        cpu_int_q <= 1'b1;
        if (cpu_int_q && !bus.buf_ack) overrun_q <= 1'b1;
      end else if (bus.buf_ack && cpu_int_q) begin
        cpu_int_q <= 1'b0;
        overrun_q <= 1'b0;
      end
    end
  end

  assign bus.bit_strobe  = strobe_q;
  assign bus.bit_index   = bit_index_q;
  assign bus.frame_index = frame_index_q;
  assign bus.bank        = bank_q;
  assign bus.ready_bank  = ready_q;
  assign bus.cpu_int     = cpu_int_q;
  assign bus.overrun     = overrun_q;
  assign bus.frame_err   = err_q;
  assign bus.locked      = locked_q;
endmodule

// File: tb/tb_tdm_frame_scheduler.sv
// Directed bench for tdm_frame_scheduler: c4 = 12 clk50 periods, f0 pulses of one c4 period.
// Each c4 cycle is driven from a clk50 falling edge; outputs are sampled 1 ns after each rising edge.
module tb_tdm_frame_scheduler;
  localparam int BIT_W = 5;
  localparam int FRM_W = 1;

  logic clk50 = 1'b0;
  logic reset = 1'b1;

  tdm_frame_scheduler_if #(.BIT_W(BIT_W), .FRM_W(FRM_W)) bus ();

  tdm_frame_scheduler #(
    .BITS_PER_FRAME(32), .FRAMES_PER_BUFFER(2), .BIT_W(BIT_W), .FRM_W(FRM_W)
  ) dut (
    .clk50(clk50), .reset(reset), .bus(bus)
  );

  always #10 clk50 = ~clk50;

  logic [13:0] outs;
  assign outs = {bus.bit_strobe, bus.bit_index, bus.frame_index, bus.bank, bus.ready_bank,
                 bus.cpu_int, bus.overrun, bus.frame_err, bus.locked};

  int n_pass = 0;
  int n_chk  = 0;
  int n_str, seq_bad, n_err, exp_idx;
  logic s_cpu, s_rdy, s_bank, s_frm, s_ovr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
  endtask

  // Strobes must land 3 edges after the c4 pin rise (k == 3) in ascending slot order.
  task automatic sample(input int k);
    if (bus.bit_strobe) begin
      if (k != 3 || bus.bit_index !== exp_idx[BIT_W-1:0]) seq_bad++;
      exp_idx++;
      n_str++;
      if (bus.bit_index == 5'd31) begin
        s_cpu  = bus.cpu_int;
        s_rdy  = bus.ready_bank;
        s_bank = bus.bank;
        s_frm  = bus.frame_index[0];
        s_ovr  = bus.overrun;
      end
    end
    if (bus.frame_err) n_err++;
  endtask

  // Entered and left on a clk50 falling edge; c4 low for k=-6..-1, high for k=0..5.
  task automatic c4_cycle(input logic f0v, input logic ack);
    bus.f0 = f0v;
    bus.c4 = 1'b0;
    for (int k = -6; k < 6; k++) begin
      if (k == 0) bus.c4 = 1'b1;
      bus.buf_ack = ack && (k == 3);
      @(posedge clk50); #1;
      bus.buf_ack = 1'b0;
      sample(k);
      @(negedge clk50);
    end
  endtask

  task automatic frame(input logic sync, input int len, input int ack_c4);
    n_str = 0; seq_bad = 0; n_err = 0; exp_idx = 0;
    s_cpu = 1'bx; s_rdy = 1'bx; s_bank = 1'bx; s_frm = 1'bx; s_ovr = 1'bx;
    for (int c = 0; c < len; c++) c4_cycle(!(sync && c == 0), c == ack_c4);
  endtask

  initial begin
    bus.c4 = 1'b0; bus.f0 = 1'b1; bus.enable = 1'b1; bus.buf_ack = 1'b0;
    repeat (3) @(posedge clk50); #1;
    check("reset_outputs", outs, 0);
    @(negedge clk50); reset = 1'b0;

    frame(0, 4, -1);
    check("preroll_strobes", n_str, 0);

    // Lock acquisition: HUNT->ALIGN, then LOCKED at the second sync.
    frame(1, 64, -1);
    check("align_strobes", n_str, 0);
    check("align_locked", bus.locked, 0);
    frame(1, 64, -1);
    check("lock_strobes", n_str, 32);
    check("lock_seq", seq_bad, 0);
    check("lock_locked", bus.locked, 1);
    check("lock_err", n_err, 0);
    check("f0_frame_index", s_frm, 0);
    check("f0_cpu_int", s_cpu, 0);

    // First bank completes on slot 31 of frame 1.
    frame(1, 64, -1);
    check("bank0_cpu_int", s_cpu, 1);
    check("bank0_ready", s_rdy, 0);
    check("bank0_bank", s_bank, 1);
    check("bank0_frame_index", s_frm, 1);

    // No ack for two more frames: second completion overruns.
    frame(1, 64, -1);
    frame(1, 64, -1);
    check("ovr_cpu_int", s_cpu, 1);
    check("ovr_overrun", s_ovr, 1);
    check("ovr_ready", s_rdy, 1);
    check("ovr_bank", s_bank, 0);
    bus.buf_ack = 1'b1;
    @(posedge clk50); #1;
    bus.buf_ack = 1'b0;
    check("ack_cpu_int", bus.cpu_int, 0);
    check("ack_overrun", bus.overrun, 0);
    @(negedge clk50);

    // Completion with cpu_int low, then a completion colliding with buf_ack.
    frame(1, 64, -1);
    frame(1, 64, -1);
    check("bank2_cpu_int", s_cpu, 1);
    check("bank2_overrun", s_ovr, 0);
    check("bank2_ready", s_rdy, 0);
    frame(1, 64, -1);
    frame(1, 64, 62);
    check("coll_cpu_int", s_cpu, 1);
    check("coll_overrun", s_ovr, 0);
    check("coll_ready", s_rdy, 1);
    check("coll_cpu_int_after", bus.cpu_int, 1);

    // Early sync at ph = 20 during frame 1 of a bank.
    frame(1, 64, -1);
    frame(1, 21, -1);
    check("pre_early_strobes", n_str, 11);
    check("pre_early_frame_index", bus.frame_index, 1);
    frame(1, 64, -1);
    check("early_err", n_err, 1);
    check("early_strobes", n_str, 0);
    check("early_locked", bus.locked, 0);
    check("early_frame_index", bus.frame_index, 0);
    frame(1, 64, -1);
    check("relock_strobes", n_str, 32);
    check("relock_seq", seq_bad, 0);
    check("relock_locked", bus.locked, 1);
    check("relock_err", n_err, 0);

    // Missing sync: error at the wrap, then two frames to relock.
    frame(0, 64, -1);
    check("miss_err", n_err, 1);
    check("miss_strobes", n_str, 0);
    check("miss_locked", bus.locked, 0);
    frame(1, 64, -1);
    check("miss_align_strobes", n_str, 0);
    frame(1, 64, -1);
    check("miss_relock_strobes", n_str, 32);
    check("miss_relock_locked", bus.locked, 1);

    // Asynchronous reset at ph = 30 while locked with cpu_int pending.
    frame(1, 31, -1);
    check("prereset_locked", bus.locked, 1);
    check("prereset_cpu_int", bus.cpu_int, 1);
    check("prereset_bit_index", bus.bit_index, 15);
    reset = 1'b1;
    #1;
    check("async_reset_outputs", outs, 0);
    @(negedge clk50);
    @(negedge clk50);
    reset = 1'b0;
    frame(0, 4, -1);
    frame(1, 64, -1);
    check("post_reset_align_strobes", n_str, 0);
    frame(1, 64, -1);
    check("post_reset_strobes", n_str, 32);
    check("post_reset_seq", seq_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
